// File: rtl/expu_elastic_pipe_if.sv
// Beat handshake bundle for the EXPU elastic pipe.
// Directions are named from the pipe's side (slave modport).
interface expu_elastic_pipe_if #(
  parameter int WIDTH     = 16,
  parameter int N_ROWS    = 8,
  parameter int TAG_WIDTH = 4
);
  logic                      valid_i;
  logic                      ready_o;
  logic [N_ROWS-1:0]         strb_i;
  logic [N_ROWS*WIDTH-1:0]   op_i;
  logic [TAG_WIDTH-1:0]      tag_i;
  logic                      valid_o;
  logic                      ready_i;
  logic [N_ROWS-1:0]         strb_o;
  logic [N_ROWS*WIDTH-1:0]   res_o;
  logic [TAG_WIDTH-1:0]      tag_o;

  modport master (
    output valid_i, strb_i, op_i, tag_i, ready_i,
    input  ready_o, valid_o, strb_o, res_o, tag_o
  );

  modport slave (
    input  valid_i, strb_i, op_i, tag_i, ready_i,
    output ready_o, valid_o, strb_o, res_o, tag_o
  );
endinterface

// File: rtl/expu_elastic_pipe.sv
// Elastic valid/ready pipeline shell for EXPU row lanes.
// Optional stall counter: define EXPU_ELASTIC_PIPE_STALL_CNT_EN.
module expu_elastic_pipe #(
  parameter int WIDTH     = 16,
  parameter int N_ROWS    = 8,
  parameter int NUM_REGS  = 5,
  parameter int TAG_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  enable_i,
  expu_elastic_pipe_if.slave    io,
  output logic [3:0]            occupancy_o,
  output logic [31:0]           stall_cnt_o
);

  localparam int L  = NUM_REGS - 1;
  localparam int DW = N_ROWS * WIDTH;

  logic [NUM_REGS-1:0]                 v_q, v_d;
  logic [NUM_REGS-1:0]                 adv, ld;
  logic [NUM_REGS-1:0][N_ROWS-1:0]     strb_q, strb_src;
  logic [NUM_REGS-1:0][DW-1:0]         data_q, data_src;
  logic [NUM_REGS-1:0][TAG_WIDTH-1:0]  tag_q, tag_src;
  logic [3:0]                          occ_q, occ_d;
  logic [DW-1:0]                       op_mask;
  logic                                acc;
  logic                                nxt;

  always_comb begin
    op_mask = '0;
    for (int k = 0; k < N_ROWS; k++) begin
      if (io.strb_i[k]) op_mask[k*WIDTH +: WIDTH] = io.op_i[k*WIDTH +: WIDTH];
    end
  end

  // Advance ripples back from the output: a stage moves if its successor
  // is empty or moving itself this cycle.
  always_comb begin
    adv    = '0;
    nxt    = v_q[L] & io.ready_i;
    adv[L] = nxt;
    for (int s = L - 1; s >= 0; s--) begin
      nxt    = v_q[s] & (~v_q[s+1] | nxt);
      adv[s] = nxt;
    end
  end

  assign io.ready_o = enable_i & ~clear_i & (~v_q[0] | adv[0]);
  assign acc        = io.valid_i & io.ready_o;

  always_comb begin
    ld          = '0;
    ld[0]       = acc;
    strb_src    = '0;
    data_src    = '0;
    tag_src     = '0;
    strb_src[0] = io.strb_i;
    data_src[0] = op_mask;
    tag_src[0]  = io.tag_i;
    for (int s = 1; s < NUM_REGS; s++) begin
      ld[s]       = adv[s-1];
      strb_src[s] = strb_q[s-1];
      data_src[s] = data_q[s-1];
      tag_src[s]  = tag_q[s-1];
    end
  end

  always_comb begin
    v_d   = ld | (v_q & ~adv);
    occ_d = '0;
    for (int s = 0; s < NUM_REGS; s++) begin
      occ_d = occ_d + {3'd0, v_d[s]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q    <= '0;
      occ_q  <= '0;
      strb_q <= '0;
      data_q <= '0;
      tag_q  <= '0;
    end else if (enable_i) begin
      v_q   <= clear_i ? '0 : v_d;
      occ_q <= clear_i ? '0 : occ_d;
      for (int s = 0; s < NUM_REGS; s++) begin
        if (ld[s] && !clear_i) begin
          strb_q[s] <= strb_src[s];
          data_q[s] <= data_src[s];
          tag_q[s]  <= tag_src[s];
        end
      end
    end
  end

  assign io.valid_o  = enable_i & v_q[L];
  assign io.strb_o   = strb_q[L];
  assign io.res_o    = data_q[L];
  assign io.tag_o    = tag_q[L];
  assign occupancy_o = occ_q;

`ifdef EXPU_ELASTIC_PIPE_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (enable_i & v_q[L] & ~io.ready_i & ~(&stall_q)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
